// File: rtl/ball_engine_if.sv
// Bus between the game controller and ball_engine: frame/serve/paddle inputs and ball state outputs.
// Optional speed-up feature of the engine is controlled by the BALL_SPEEDUP_EN macro.
interface ball_engine_if #(
   parameter int CW = 11
);
   logic          frame_tick;
   logic          serve;
   logic [CW-1:0] y_pad_left;
   logic [CW-1:0] y_pad_right;
   logic [CW-1:0] x_ball;
   logic [CW-1:0] y_ball;
   logic          miss_left;
   logic          miss_right;
   logic          hit;
   logic [3:0]    speed;
   logic          busy;

   modport master (
      output frame_tick, serve, y_pad_left, y_pad_right,
      input  x_ball, y_ball, miss_left, miss_right, hit, speed, busy
   );

   modport slave (
      input  frame_tick, serve, y_pad_left, y_pad_right,
      output x_ball, y_ball, miss_left, miss_right, hit, speed, busy
   );
endinterface

// File: rtl/ball_engine.sv
// Pong ball engine: serve delay, per-frame motion, wall/paddle bounces and miss detection.
// Define BALL_SPEEDUP_EN to enable the paddle-hit speed-up with saturating speed.
module ball_engine #(
   parameter int HOR_PIXELS    = 1024,
   parameter int VER_PIXELS    = 768,
   parameter int BALL_SIZE     = 16,
   parameter int PAD_W         = 16,
   parameter int PAD_H         = 145,
   parameter int X_PAD_L       = 30,
   parameter int X_PAD_R       = 979,
   parameter int WALL          = 8,
   parameter int SPEED_INIT    = 2,
   parameter int SPEED_MAX     = 8,
   parameter int HITS_PER_STEP = 4,
   parameter int SERVE_DELAY   = 60,
   parameter int CW            = 11
) (
   input  logic         clk,
   input  logic         rst,
   ball_engine_if.slave bus
);

   localparam int W   = CW + 1;
   localparam int TCW = (SERVE_DELAY > 1) ? $clog2(SERVE_DELAY) : 1;

   localparam logic [1:0] IDLE  = 2'd0;
   localparam logic [1:0] SERVE = 2'd1;
   localparam logic [1:0] PLAY  = 2'd2;
   localparam logic [1:0] MISS  = 2'd3;

   localparam logic [CW-1:0]  X_CTR     = CW'((HOR_PIXELS - BALL_SIZE) / 2);
   localparam logic [CW-1:0]  Y_CTR     = CW'((VER_PIXELS - BALL_SIZE) / 2);
   localparam logic [CW-1:0]  Y_TOP     = CW'(WALL);
   localparam logic [CW-1:0]  Y_BOT     = CW'(VER_PIXELS - WALL - BALL_SIZE);
   localparam logic [CW-1:0]  X_LSTOP   = CW'(X_PAD_L + PAD_W);
   localparam logic [CW-1:0]  X_RSTOP   = CW'(X_PAD_R - BALL_SIZE);
   localparam logic [3:0]     SPD_INIT  = 4'(SPEED_INIT);
   localparam logic [3:0]     SPD_MAX   = 4'(SPEED_MAX);
   localparam logic [TCW-1:0] LAST_TICK = TCW'(SERVE_DELAY - 1);

   localparam logic signed [W-1:0] S_ZERO  = '0;
   localparam logic signed [W-1:0] S_WALL  = W'(WALL);
   localparam logic signed [W-1:0] S_BOT   = W'(VER_PIXELS - WALL);
   localparam logic signed [W-1:0] S_BALL  = W'(BALL_SIZE);
   localparam logic signed [W-1:0] S_LEDGE = W'(X_PAD_L + PAD_W);
   localparam logic signed [W-1:0] S_REDGE = W'(X_PAD_R);
   localparam logic signed [W-1:0] S_HOR   = W'(HOR_PIXELS);

   logic [1:0]     state_q, state_d;
   logic [CW-1:0]  xBall_q, xBall_d;
   logic [CW-1:0]  yBall_q, yBall_d;
   logic           dirRight_q, dirRight_d;
   logic           dirDown_q, dirDown_d;
   logic [3:0]     speed_q, speed_d;
   logic [TCW-1:0] tickCnt_q, tickCnt_d;
   logic           tickDly_q;
   logic           hit_q, hit_d;
   logic           missLeft_q, missLeft_d;
   logic           missRight_q, missRight_d;

   logic signed [W-1:0] xS, yS, spS, nextX, nextY;
   logic [W-1:0]        yTop, yBottom, padLTop, padLBot, padRTop, padRBot;
   logic                overlapL, overlapR, hitL, hitR, missL, missR, topHit, botHit;
   logic                hitNow, speedUp;

   // Candidate positions are signed so a step past 0 shows up as negative rather than wrapping.
   assign xS    = $signed({1'b0, xBall_q});
   assign yS    = $signed({1'b0, yBall_q});
   assign spS   = $signed(W'(speed_q));
   assign nextX = dirRight_q ? (xS + spS) : (xS - spS);
   assign nextY = dirDown_q  ? (yS + spS) : (yS - spS);

   assign yTop     = {1'b0, yBall_q};
   assign yBottom  = yTop + W'(BALL_SIZE);
   assign padLTop  = {1'b0, bus.y_pad_left};
   assign padLBot  = padLTop + W'(PAD_H);
   assign padRTop  = {1'b0, bus.y_pad_right};
   assign padRBot  = padRTop + W'(PAD_H);
   assign overlapL = (yBottom > padLTop) && (yTop < padLBot);
   assign overlapR = (yBottom > padRTop) && (yTop < padRBot);

   assign hitL   = !dirRight_q && (xS >= S_LEDGE) && (nextX <= S_LEDGE) && overlapL;
   assign hitR   = dirRight_q && (xS + S_BALL <= S_REDGE) && (nextX + S_BALL >= S_REDGE) && overlapR;
   assign missL  = !dirRight_q && !hitL && (nextX <= S_ZERO);
   assign missR  = dirRight_q && !hitR && (nextX + S_BALL >= S_HOR);
   assign topHit = !dirDown_q && (nextY <= S_WALL);
   assign botHit = dirDown_q && (nextY + S_BALL >= S_BOT);

   assign hitNow = (state_q == PLAY) && tickDly_q && (hitL || hitR);

`ifdef BALL_SPEEDUP_EN
   localparam int HCW = (HITS_PER_STEP > 1) ? $clog2(HITS_PER_STEP) : 1;
   localparam logic [HCW-1:0] LAST_HIT = HCW'(HITS_PER_STEP - 1);

   logic [HCW-1:0] hitCnt_q, hitCnt_d;

   always_comb begin
      hitCnt_d = hitCnt_q;
      speedUp  = 1'b0;
      if (state_q == MISS) begin
         hitCnt_d = '0;
      end else if (hitNow) begin
         if (hitCnt_q == LAST_HIT) begin
            hitCnt_d = '0;
            speedUp  = 1'b1;
         end else begin
            hitCnt_d = hitCnt_q + 1'b1;
         end
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         hitCnt_q <= '0;
      end else begin
         hitCnt_q <= hitCnt_d;
      end
   end
`else
   assign speedUp = 1'b0;
`endif

   // Motion happens only in the cycle after frame_tick; paddles are looked at only then.
   always_comb begin
      state_d     = state_q;
      xBall_d     = xBall_q;
      yBall_d     = yBall_q;
      dirRight_d  = dirRight_q;
      dirDown_d   = dirDown_q;
      speed_d     = speed_q;
      tickCnt_d   = tickCnt_q;
      hit_d       = 1'b0;
      missLeft_d  = 1'b0;
      missRight_d = 1'b0;
      case (state_q)
         IDLE: begin
            if (bus.serve) begin
               state_d   = SERVE;
               tickCnt_d = '0;
            end
         end
         SERVE: begin
            if (tickDly_q) begin
               if (tickCnt_q == LAST_TICK) begin
                  state_d   = PLAY;
                  tickCnt_d = '0;
               end else begin
                  tickCnt_d = tickCnt_q + 1'b1;
               end
            end
         end
         PLAY: begin
            if (tickDly_q) begin
               if (topHit) begin
                  yBall_d   = Y_TOP;
                  dirDown_d = 1'b1;
               end else if (botHit) begin
                  yBall_d   = Y_BOT;
                  dirDown_d = 1'b0;
               end else begin
                  yBall_d = nextY[CW-1:0];
               end
               if (hitL) begin
                  xBall_d    = X_LSTOP;
                  dirRight_d = 1'b1;
                  hit_d      = 1'b1;
               end else if (hitR) begin
                  xBall_d    = X_RSTOP;
                  dirRight_d = 1'b0;
                  hit_d      = 1'b1;
               end else if (missL) begin
                  missLeft_d = 1'b1;
                  state_d    = MISS;
               end else if (missR) begin
                  missRight_d = 1'b1;
                  state_d     = MISS;
               end else begin
                  xBall_d = nextX[CW-1:0];
               end
               if (speedUp && (speed_q < SPD_MAX)) begin
                  speed_d = speed_q + 4'd1;
               end
            end
         end
         MISS: begin
            xBall_d    = X_CTR;
            yBall_d    = Y_CTR;
            speed_d    = SPD_INIT;
            dirRight_d = missRight_q;
            tickCnt_d  = '0;
            state_d    = SERVE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q     <= IDLE;
         xBall_q     <= X_CTR;
         yBall_q     <= Y_CTR;
         dirRight_q  <= 1'b1;
         dirDown_q   <= 1'b1;
         speed_q     <= SPD_INIT;
         tickCnt_q   <= '0;
         tickDly_q   <= 1'b0;
         hit_q       <= 1'b0;
         missLeft_q  <= 1'b0;
         missRight_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         xBall_q     <= xBall_d;
         yBall_q     <= yBall_d;
         dirRight_q  <= dirRight_d;
         dirDown_q   <= dirDown_d;
         speed_q     <= speed_d;
         tickCnt_q   <= tickCnt_d;
         tickDly_q   <= bus.frame_tick;
         hit_q       <= hit_d;
         missLeft_q  <= missLeft_d;
         missRight_q <= missRight_d;
      end
   end

   assign bus.x_ball     = xBall_q;
   assign bus.y_ball     = yBall_q;
   assign bus.miss_left  = missLeft_q;
   assign bus.miss_right = missRight_q;
   assign bus.hit        = hit_q;
   assign bus.speed      = speed_q;
   assign bus.busy       = (state_q != IDLE);

endmodule
